// File: rtl/fx2_fifo_arbiter_if.sv
// rtl/fx2_fifo_arbiter_if.sv - FX2 slave-FIFO bus plus internal IN/OUT stream signals
// master: driven by the arbiter (fifoadr, strobes, fx2_dout, in_ready, out_data, out_valid)
// slave : driven by the FX2 pins and the internal producer/consumer
interface fx2_fifo_arbiter_if;
    logic [1:0] fifoadr;
    logic       fx2_wr;
    logic       fx2_rd;
    logic       fx2_pktend;
    logic [7:0] fx2_dout;
    logic [7:0] fx2_din;
    logic       fx2_full;
    logic       fx2_empty;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       in_flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output fifoadr, fx2_wr, fx2_rd, fx2_pktend, fx2_dout, in_ready, out_data, out_valid,
        input  fx2_din, fx2_full, fx2_empty, in_data, in_valid, in_flush, out_ready
    );

    modport slave (
        input  fifoadr, fx2_wr, fx2_rd, fx2_pktend, fx2_dout, in_ready, out_data, out_valid,
        output fx2_din, fx2_full, fx2_empty, in_data, in_valid, in_flush, out_ready
    );
endinterface

// File: rtl/fx2_fifo_arbiter.sv
// rtl/fx2_fifo_arbiter.sv - round-robin, burst-limited sharing of the FX2 slave-FIFO bus
// Ports: ifclk (bus clock), reset (sync, active-high), bus (fx2_fifo_arbiter_if.master:
// FX2 address/strobes/data plus IN stream sink and OUT stream source), busy (not IDLE).
module fx2_fifo_arbiter #(
    parameter logic [1:0]  IN_FIFOADR  = 2'b10,
    parameter logic [1:0]  OUT_FIFOADR = 2'b00,
    parameter int unsigned BURST_MAX   = 16,
    parameter int unsigned ADR_SETTLE  = 1
) (
    input  logic                ifclk,
    input  logic                reset,
    fx2_fifo_arbiter_if.master  bus,
    output logic                busy
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WRITE,
        ST_READ,
        ST_PKTEND
    } state_t;

    localparam logic [8:0] BURST_LIM   = 9'(BURST_MAX);
    localparam logic [2:0] SETTLE_LAST = 3'(ADR_SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] fifoadr_q, fifoadr_d;
    logic       flush_pending_q, flush_pending_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rr_out_q, rr_out_d;       // 1: OUT wins the next contested grant
    logic       grant_out_q, grant_out_d; // direction to enter once SETTLE completes
    logic [2:0] settle_q, settle_d;

    logic       req_in, req_out, grant_out;
    logic [1:0] grant_adr;
    logic       wr_acc, rd_acc, pktend_s;
    logic [8:0] cnt_next;
    logic       burst_done;

    assign req_in     = bus.in_valid | flush_pending_q;
    assign req_out    = ~bus.fx2_empty;
    assign grant_out  = req_out & (~req_in | rr_out_q);
    assign grant_adr  = grant_out ? OUT_FIFOADR : IN_FIFOADR;

    assign wr_acc     = (state_q == ST_WRITE) & bus.in_valid & ~bus.fx2_full;
    assign rd_acc     = (state_q == ST_READ) & ~bus.fx2_empty & bus.out_ready;
    assign pktend_s   = (state_q == ST_PKTEND) & ~bus.fx2_full;

    // Compare includes the byte moved this cycle so a grant moves exactly BURST_MAX bytes.
    assign cnt_next   = {1'b0, cnt_q} + 9'(wr_acc | rd_acc);
    assign burst_done = (cnt_next == BURST_LIM);

    assign busy       = (state_q != ST_IDLE);
    assign bus.fifoadr = fifoadr_q;

    always_comb begin
        state_d         = state_q;
        fifoadr_d       = fifoadr_q;
        cnt_d           = cnt_q;
        rr_out_d        = rr_out_q;
        grant_out_d     = grant_out_q;
        settle_d        = settle_q;
        bus.fx2_wr      = 1'b0;
        bus.fx2_rd      = 1'b0;
        bus.fx2_pktend  = 1'b0;
        bus.fx2_dout    = 8'h00;
        bus.in_ready    = 1'b0;
        bus.out_valid   = 1'b0;
        bus.out_data    = bus.fx2_din;
        // A new flush in the same cycle as pktend must survive, so the set term wins.
        flush_pending_d = bus.in_flush | (flush_pending_q & ~pktend_s);

        case (state_q)
            ST_IDLE: begin
                if (req_in | req_out) begin
                    rr_out_d    = ~rr_out_q;
                    grant_out_d = grant_out;
                    cnt_d       = 8'h00;
                    if (grant_adr == fifoadr_q) begin
                        state_d = grant_out ? ST_READ : ST_WRITE;
                    end else begin
                        fifoadr_d = grant_adr;
                        settle_d  = 3'd0;
                        state_d   = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = grant_out_q ? ST_READ : ST_WRITE;
                    cnt_d   = 8'h00;
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end
            ST_WRITE: begin
                bus.fx2_wr   = wr_acc;
                bus.in_ready = wr_acc;
                bus.fx2_dout = bus.in_data;
                cnt_d        = cnt_next[7:0];
                if (flush_pending_q && (!bus.in_valid || burst_done)) begin
                    state_d = ST_PKTEND;
                end else if (burst_done || !bus.in_valid || bus.fx2_full) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                bus.out_valid = ~bus.fx2_empty;
                bus.fx2_rd    = rd_acc;
                cnt_d         = cnt_next[7:0];
                if (burst_done || bus.fx2_empty || (!bus.out_ready && req_in)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PKTEND: begin
                bus.fx2_pktend = pktend_s;
                if (!bus.fx2_full) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            fifoadr_q       <= IN_FIFOADR;
            flush_pending_q <= 1'b0;
            cnt_q           <= 8'h00;
            rr_out_q        <= 1'b0;
            grant_out_q     <= 1'b0;
            settle_q        <= 3'd0;
        end else begin
            state_q         <= state_d;
            fifoadr_q       <= fifoadr_d;
            flush_pending_q <= flush_pending_d;
            cnt_q           <= cnt_d;
            rr_out_q        <= rr_out_d;
            grant_out_q     <= grant_out_d;
            settle_q        <= settle_d;
        end
    end
endmodule

// File: tb/tb_fx2_fifo_arbiter.sv
// tb/tb_fx2_fifo_arbiter.sv - scoreboard bench for fx2_fifo_arbiter
module tb_fx2_fifo_arbiter;
    localparam int BURST_MAX  = 16;
    localparam int ADR_SETTLE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    fx2_fifo_arbiter_if bus ();

    fx2_fifo_arbiter #(
        .IN_FIFOADR(2'b10), .OUT_FIFOADR(2'b00), .BURST_MAX(BURST_MAX), .ADR_SETTLE(ADR_SETTLE)
    ) dut (
        .ifclk(clk), .reset(rst), .bus(bus), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] in_src[$];   // bytes offered by the IN producer
    logic [7:0] exp_in[$];   // bytes expected on fx2_dout, in order
    logic [7:0] ep2[$];      // bytes held in the host-side OUT endpoint
    logic [7:0] exp_out[$];  // bytes expected on out_data, in order
    int         bursts[$];

    int  in_on = 0, in_pct = 100, out_pct = 100, full_pct = 0;
    bit  full_force = 0, flush_req = 0;
    bit  pend = 0;
    int  wr_total = 0, rd_total = 0, pk_total = 0, adr_changes = 0;
    int  adr_age = 0, run = 0;
    logic [1:0] last_adr = 2'b10;
    logic [7:0] in_seq = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.in_valid  = (in_on != 0) && (in_src.size() > 0) && ($urandom_range(99) < in_pct);
        bus.in_data   = (in_src.size() > 0) ? in_src[0] : 8'h00;
        bus.fx2_empty = (ep2.size() == 0);
        bus.fx2_din   = (ep2.size() > 0) ? ep2[0] : 8'h00;
        bus.out_ready = ($urandom_range(99) < out_pct);
        bus.fx2_full  = full_force || ($urandom_range(99) < full_pct);
        bus.in_flush  = flush_req;
        flush_req     = 0;
    endtask

    task automatic push_in(input int n);
        for (int i = 0; i < n; i++) begin
            in_src.push_back(in_seq);
            exp_in.push_back(in_seq);
            in_seq = in_seq + 8'd1;
        end
    endtask

    task automatic push_out(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(255));
            ep2.push_back(b);
            exp_out.push_back(b);
        end
    endtask

    task automatic drain(input string name, input int max);
        for (int n = 0; n < max && (exp_in.size() > 0 || exp_out.size() > 0); n++) step();
        chk(name, exp_in.size() + exp_out.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_fifoadr"}, int'(bus.fifoadr), 2);
        chk({tag, "_strobes"}, int'(bus.fx2_wr) + int'(bus.fx2_rd) + int'(bus.fx2_pktend), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_dout"}, int'(bus.fx2_dout), 0);
    endtask

    // Monitor: observes the bus mid-cycle and checks it against the endpoint/stream model.
    always @(negedge clk) begin
        bit wr, rd, pk;
        wr = bus.fx2_wr;
        rd = bus.fx2_rd;
        pk = bus.fx2_pktend;
        if (bus.fifoadr !== last_adr) begin
            adr_changes++;
            adr_age = 0;
        end else if (adr_age < 1000) begin
            adr_age++;
        end
        last_adr = bus.fifoadr;
        if (wr || rd || pk) begin
            chk("strobe_onehot", int'(wr) + int'(rd) + int'(pk), 1);
            chk("strobe_after_settle", int'(adr_age >= ADR_SETTLE), 1);
        end
        if (wr || bus.in_ready) begin
            chk("in_ready_eq_wr", int'(bus.in_ready), int'(wr));
            chk("wr_fifoadr", int'(bus.fifoadr), 2);
            chk("wr_not_full", int'(bus.fx2_full), 0);
            chk("wr_in_valid", int'(bus.in_valid), 1);
            if (exp_in.size() == 0) chk("in_extra_byte", 1, 0);
            else chk("in_byte", int'(bus.fx2_dout), int'(exp_in.pop_front()));
            if (in_src.size() > 0) void'(in_src.pop_front());
            wr_total++;
        end
        if (rd || (bus.out_valid && bus.out_ready)) begin
            chk("rd_eq_handshake", int'(rd), int'(bus.out_valid && bus.out_ready));
            chk("rd_fifoadr", int'(bus.fifoadr), 0);
            chk("rd_not_empty", int'(bus.fx2_empty), 0);
            if (exp_out.size() == 0) chk("out_extra_byte", 1, 0);
            else chk("out_byte", int'(bus.out_data), int'(exp_out.pop_front()));
            if (ep2.size() > 0) void'(ep2.pop_front());
            rd_total++;
        end
        if (bus.out_valid) chk("out_valid_not_empty", int'(bus.fx2_empty), 0);
        if (pk) begin
            chk("pktend_not_full", int'(bus.fx2_full), 0);
            chk("pktend_had_flush", int'(pend), 1);
            pk_total++;
        end
        if (!busy) begin
            if (run > 0) bursts.push_back(run);
            run = 0;
        end else if (wr || rd) begin
            run++;
            chk("burst_le_max", int'(run <= BURST_MAX), 1);
        end
        pend = rst ? 1'b0 : (bus.in_flush | (pend & ~pk));
    end

    initial begin
        int snap_wr, snap_rd, snap_pk, snap_adr;
        bus.in_valid = 0; bus.in_data = 0; bus.fx2_empty = 1; bus.fx2_din = 0;
        bus.out_ready = 1; bus.fx2_full = 0; bus.in_flush = 0;

        // Reset state
        rst = 1;
        step(); step();
        @(negedge clk);
        check_idle_outputs("reset");
        step();
        rst = 0;
        step();

        // 40 IN bytes, no OUT traffic: bursts 16,16,8 with no address change
        bursts.delete();
        snap_adr = adr_changes;
        snap_wr = wr_total;
        in_on = 1; in_pct = 100; out_pct = 100; full_pct = 0;
        push_in(40);
        drain("t1_drain", 300);
        repeat (4) step();
        chk("t1_wr_count", wr_total - snap_wr, 40);
        chk("t1_adr_changes", adr_changes - snap_adr, 0);
        chk("t1_burst_n", bursts.size(), 3);
        if (bursts.size() == 3) begin
            chk("t1_burst0", bursts[0], 16);
            chk("t1_burst1", bursts[1], 16);
            chk("t1_burst2", bursts[2], 8);
        end

        // Zero-length packet from a lone flush
        snap_pk = pk_total;
        flush_req = 1;
        repeat (8) step();
        chk("zlp_pktend_count", pk_total - snap_pk, 1);
        chk("zlp_pending_clear", int'(pend), 0);

        // Host OUT bytes interleaved with a continuous IN stream
        snap_adr = adr_changes;
        push_out(5);
        push_in(60);
        drain("mix_drain", 600);
        chk("mix_adr_alternates", int'(adr_changes - snap_adr >= 2), 1);

        // fx2_full for 10 cycles mid-burst
        push_in(40);
        repeat (5) step();
        full_force = 1;
        step();
        snap_wr = wr_total;
        repeat (9) step();
        full_force = 0;
        step();
        chk("full_no_wr", wr_total - snap_wr, 0);
        drain("full_drain", 300);
        repeat (3) step();

        // Pending flush while full: held until the first non-full cycle
        snap_pk = pk_total;
        full_force = 1;
        flush_req = 1;
        step();
        repeat (8) step();
        chk("flush_full_held", pk_total - snap_pk, 0);
        full_force = 0;
        step();
        @(negedge clk);
        chk("flush_first_nonfull", int'(bus.fx2_pktend), 1);
        repeat (3) step();
        chk("flush_full_count", pk_total - snap_pk, 1);

        // READ with out_ready=0 yields to IN
        out_pct = 0;
        in_on = 0;
        push_out(3);
        repeat (6) step();
        snap_wr = wr_total;
        snap_rd = rd_total;
        push_in(20);
        in_on = 1;
        repeat (80) step();
        chk("yield_wr", wr_total - snap_wr, 20);
        chk("yield_no_rd", rd_total - snap_rd, 0);
        out_pct = 100;
        drain("yield_drain", 200);

        // Randomised traffic
        in_pct = 70; out_pct = 60; full_pct = 20;
        for (int c = 0; c < 400; c++) begin
            step();
            if ($urandom_range(99) < 30) push_in(1);
            if ($urandom_range(99) < 10) push_out(1);
            if ($urandom_range(99) < 3) flush_req = 1;
        end
        in_pct = 100; out_pct = 100; full_pct = 0;
        drain("rand_drain", 2000);
        repeat (12) step();
        chk("rand_flush_serviced", int'(pend), 0);

        // Reset mid-WRITE
        push_in(30);
        repeat (5) step();
        chk("busy_before_reset", int'(busy), 1);
        rst = 1;
        step();
        @(negedge clk);
        check_idle_outputs("midreset");
        step();
        rst = 0;
        drain("post_reset_drain", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
